// File: rtl/ip.sv
// ip: single-issue integer ALU pipe stage (RV64 funct3 ops, optional W truncation)
// with a one-entry output register and valid/ready handshakes on both sides.
//
// Parameters:
//   SER_SHIFT_STEP  shift bits per cycle for the serial shifter (1,2,4,8,16,32)
// Configuration macro:
//   IP_SERIAL_SHIFT_EN  when defined, SLL/SRL/SRA with a non-zero amount run on
//                       a multi-cycle serial shifter (FSM state SHIFT); otherwise
//                       every op completes through a single-cycle barrel shifter.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   ix_ip_*                  issue side: pc, dst, wb_en, op, option, truncate,
//                            operand1/2, valid in, ready out
//   ip_ix_*                  writeback side: dst, result, pc, wb_en, valid out,
//                            ready in
module ip #(
    parameter int unsigned SER_SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] ix_ip_pc,
    input  logic [4:0]  ix_ip_dst,
    input  logic        ix_ip_wb_en,
    input  logic [2:0]  ix_ip_op,
    input  logic        ix_ip_option,
    input  logic        ix_ip_truncate,
    input  logic [63:0] ix_ip_operand1,
    input  logic [63:0] ix_ip_operand2,
    input  logic        ix_ip_valid,
    output logic        ix_ip_ready,
    output logic [4:0]  ip_ix_dst,
    output logic [63:0] ip_ix_result,
    output logic [63:0] ip_ix_pc,
    output logic        ip_ix_wb_en,
    output logic        ip_ix_valid,
    input  logic        ip_ix_ready
);

    localparam int unsigned XLEN = 64;

    // Elaboration-time guard on the step parameter; an illegal value leaves a
    // marker block in the hierarchy.
    if (!(SER_SHIFT_STEP == 1 || SER_SHIFT_STEP == 2 || SER_SHIFT_STEP == 4 ||
          SER_SHIFT_STEP == 8 || SER_SHIFT_STEP == 16 || SER_SHIFT_STEP == 32))
    begin : g_illegal_ser_shift_step
    end

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [4:0]       dst_q, dst_d;
    logic             wb_en_q, wb_en_d;
    logic             accept;
    logic             out_free;

    // Full single-cycle ALU; W ops sign-extend result bit 31.
    function automatic logic [XLEN-1:0] alu(input logic [2:0] op, input logic opt,
                                            input logic trunc,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        logic [5:0]      sh;
        logic [XLEN-1:0] a_w;
        logic [XLEN-1:0] r;
        sh  = trunc ? {1'b0, b[4:0]} : b[5:0];
        // Right-shift source for W ops: SRAW sign-extends, SRLW zero-extends.
        a_w = trunc ? (opt ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]}) : a;
        case (op)
            3'b000:  r = opt ? (a - b) : (a + b);
            3'b001:  r = a << sh;
            3'b010:  r = {63'b0, ($signed(a) < $signed(b))};
            3'b011:  r = {63'b0, (a < b)};
            3'b100:  r = a ^ b;
            3'b101:  r = opt ? XLEN'($signed(a_w) >>> sh) : (a_w >> sh);
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        if (trunc) r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

    assign out_free    = !valid_q || ip_ix_ready;
    assign ix_ip_ready = rst && (state_q == IDLE) && out_free;
    assign accept      = ix_ip_valid && ix_ip_ready;

`ifdef IP_SERIAL_SHIFT_EN
    logic [5:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] sdata_q, sdata_d;
    logic            sleft_q, sleft_d;
    logic            sarith_q, sarith_d;
    logic            strunc_q, strunc_d;
    logic [XLEN-1:0] spc_q, spc_d;
    logic [4:0]      sdst_q, sdst_d;
    logic            swb_q, swb_d;
    logic [5:0]      shamt;
    logic [5:0]      step;
    logic [XLEN-1:0] shifted;
    logic            is_shift;

    assign shamt    = ix_ip_truncate ? {1'b0, ix_ip_operand2[4:0]} : ix_ip_operand2[5:0];
    assign is_shift = (ix_ip_op == 3'b001) || (ix_ip_op == 3'b101);
    // Step is min(SER_SHIFT_STEP, remaining); zero once the shift has finished.
    assign step     = (cnt_q < 6'(SER_SHIFT_STEP)) ? cnt_q : 6'(SER_SHIFT_STEP);
    assign shifted  = sleft_q  ? (sdata_q << step) :
                      sarith_q ? XLEN'($signed(sdata_q) >>> step) :
                                 (sdata_q >> step);
`endif

    // Next-state and output-register logic.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        result_d = result_q;
        pc_d     = pc_q;
        dst_d    = dst_q;
        wb_en_d  = wb_en_q;
`ifdef IP_SERIAL_SHIFT_EN
        cnt_d    = cnt_q;
        sdata_d  = sdata_q;
        sleft_d  = sleft_q;
        sarith_d = sarith_q;
        strunc_d = strunc_q;
        spc_d    = spc_q;
        sdst_d   = sdst_q;
        swb_d    = swb_q;
`endif

        if (valid_q && ip_ix_ready) valid_d = 1'b0;

        if (accept) begin
`ifdef IP_SERIAL_SHIFT_EN
            if (is_shift && (shamt != 6'd0)) begin
                state_d  = SHIFT;
                cnt_d    = shamt;
                sleft_d  = (ix_ip_op == 3'b001);
                sarith_d = (ix_ip_op == 3'b101) && ix_ip_option;
                strunc_d = ix_ip_truncate;
                sdata_d  = !ix_ip_truncate ? ix_ip_operand1 :
                           sarith_d ? {{32{ix_ip_operand1[31]}}, ix_ip_operand1[31:0]} :
                                      {32'b0, ix_ip_operand1[31:0]};
                spc_d    = ix_ip_pc;
                sdst_d   = ix_ip_dst;
                swb_d    = ix_ip_wb_en;
            end else
`endif
            begin
                valid_d  = 1'b1;
                result_d = alu(ix_ip_op, ix_ip_option, ix_ip_truncate,
                               ix_ip_operand1, ix_ip_operand2);
                pc_d     = ix_ip_pc;
                dst_d    = ix_ip_dst;
                wb_en_d  = ix_ip_wb_en;
            end
        end

`ifdef IP_SERIAL_SHIFT_EN
        // Step the shifter; the finished value parks here until OUT frees up.
        if (state_q == SHIFT) begin
            sdata_d = shifted;
            cnt_d   = cnt_q - step;
            if ((cnt_d == 6'd0) && out_free) begin
                state_d  = IDLE;
                valid_d  = 1'b1;
                result_d = strunc_q ? {{32{shifted[31]}}, shifted[31:0]} : shifted;
                pc_d     = spc_q;
                dst_d    = sdst_q;
                wb_en_d  = swb_q;
            end
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            pc_q     <= '0;
            dst_q    <= '0;
            wb_en_q  <= 1'b0;
`ifdef IP_SERIAL_SHIFT_EN
            cnt_q    <= '0;
            sdata_q  <= '0;
            sleft_q  <= 1'b0;
            sarith_q <= 1'b0;
            strunc_q <= 1'b0;
            spc_q    <= '0;
            sdst_q   <= '0;
            swb_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            pc_q     <= pc_d;
            dst_q    <= dst_d;
            wb_en_q  <= wb_en_d;
`ifdef IP_SERIAL_SHIFT_EN
            cnt_q    <= cnt_d;
            sdata_q  <= sdata_d;
            sleft_q  <= sleft_d;
            sarith_q <= sarith_d;
            strunc_q <= strunc_d;
            spc_q    <= spc_d;
            sdst_q   <= sdst_d;
            swb_q    <= swb_d;
`endif
        end
    end

    assign ip_ix_valid  = valid_q;
    assign ip_ix_result = result_q;
    assign ip_ix_pc     = pc_q;
    assign ip_ix_dst    = dst_q;
    assign ip_ix_wb_en  = wb_en_q;

endmodule
